// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_BYTES = 4;
    localparam int INSTR_WIDTH = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - 2-entry FIFO of fetched {pc, instr} pairs
import fetch_pkg::*;

module fetch_skid_buf (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         head_q;
    logic [1:0]   count_q;
    logic         tail;

    // Tail slot is computed against the pre-pop head, so push+pop in one cycle is safe.
    assign tail = head_q ^ count_q[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            head_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[tail] <= push_data_i;
            end
            if (pop_i) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, IRAM issue, in-flight tracking and decode handshake
import fetch_pkg::*;

module instr_fetch #(
    parameter int          DATAWIDTH = 32,
    parameter int          ADDRWIDTH = 5,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [ADDRWIDTH-1:0] iram_addr_o,
    input  logic [DATAWIDTH-1:0] iram_data_i,
    input  logic                 halt_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [31:0]          pc_o
);

    fetch_state_t          state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  inflight_q;
    logic [PC_WIDTH-1:0]   inflight_pc_q;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  issue;
    logic                  capture;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign valid_o   = (count != 2'd0);
    assign pop       = valid_o & ready_i;
    // Slots that will be occupied once the in-flight read lands and the current pop retires.
    assign occupancy = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue     = (state_q == RUN) && !halt_i && !redirect_i && (occupancy < 3'd2);
    assign capture   = inflight_q & ~redirect_i;

    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = iram_data_i;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~32'h3;
        end else if (issue) begin
            pc_d = pc_q + PC_WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            case (state_q)
                RUN:     if (halt_i)  state_q <= HALT;
                HALT:    if (!halt_i) state_q <= RUN;
                default: state_q <= RUN;
            endcase
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    fetch_skid_buf u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (capture),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .count_o     (count),
        .head_o      (head)
    );

    assign iram_addr_o = pc_q[ADDRWIDTH+1:2];
    assign instr_o     = head.instr;
    assign pc_o        = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with an in-order PC scoreboard
module tb_instr_fetch;

    localparam int          DW       = 32;
    localparam int          AW       = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] iram_addr_o;
    logic [DW-1:0] iram_data_i;
    logic          halt_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] instr_o;
    logic [31:0]   pc_o;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] a0;

    always #5 clk = ~clk;

    instr_fetch #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .iram_addr_o   (iram_addr_o),
        .iram_data_i   (iram_data_i),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    function automatic logic [31:0] iram_word(input logic [31:0] word_idx);
        return 32'h1000_0000 + (word_idx % 32);
    endfunction

    always @(posedge clk) iram_data_i <= iram_word({27'd0, iram_addr_o});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already set; scores any pop, then advances one cycle.
    task automatic tick();
        if (!rst_i && valid_o && ready_i) begin
            check("sb_pc", pc_o, exp_pc);
            check("sb_instr", instr_o, iram_word(exp_pc >> 2));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect_i) exp_pc = redirect_pc_i & ~32'h3;
        if (rst_i) exp_pc = RESET_PC;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            check("stream_valid", {31'd0, valid_o}, 32'd1);
            check("stream_addr", {27'd0, iram_addr_o}, ((pc_o >> 2) + 32'd2) % 32);
            tick();
        end
    endtask

    initial begin
        rst_i = 1'b1; ready_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_addr", {27'd0, iram_addr_o}, (RESET_PC >> 2) % 32);

        rst_i = 1'b0; ready_i = 1'b1;
        check("first_c0_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("first_c1_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("first_c2_valid", {31'd0, valid_o}, 32'd1);
        check("first_pc", pc_o, RESET_PC);
        stream(40);

        ready_i = 1'b0;
        a0 = {27'd0, iram_addr_o};
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, valid_o}, 32'd1);
            check("stall_addr_frozen", {27'd0, iram_addr_o}, a0);
            tick();
        end
        ready_i = 1'b1;
        tick();
        stream(10);

        ready_i = 1'b0;
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
        tick();
        redirect_i = 1'b0; ready_i = 1'b1;
        check("redir_t1_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("redir_t2_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("redir_t3_valid", {31'd0, valid_o}, 32'd1);
        check("redir_t3_pc", pc_o, 32'h0000_0040);
        stream(6);

        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0043;
        a0 = pops;
        tick();
        check("redir_pop_counted", pops - a0, 32'd1);
        redirect_i = 1'b0;
        check("redir_pop_empty", {31'd0, valid_o}, 32'd0);
        tick();
        check("redir_pop_t2_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("redir_pop_t3_pc", pc_o, 32'h0000_0040);
        stream(6);

        halt_i = 1'b1;
        a0 = {27'd0, iram_addr_o};
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            check("halt_addr_frozen", {27'd0, iram_addr_o}, a0);
            if (i == 2) check("halt_drained", {31'd0, valid_o}, 32'd0);
            tick();
        end
        check("halt_inflight_delivered", pops, 32'd2);
        halt_i = 1'b0;
        check("halt_exit_addr", {27'd0, iram_addr_o}, a0);
        tick();
        tick();
        tick();
        stream(6);

        halt_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_halt_valid", {31'd0, valid_o}, 32'd0);
        check("rst_halt_addr", {27'd0, iram_addr_o}, (RESET_PC >> 2) % 32);
        halt_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        redirect_i = 1'b0;
        tick();
        tick();
        check("wrap_pc_first", pc_o, 32'hFFFF_FFF8);
        stream(6);

        pops = 0;
        for (int i = 0; i < 800; i++) begin
            ready_i       = ($urandom_range(0, 9) < 7);
            halt_i        = ($urandom_range(0, 19) == 0);
            redirect_i    = ($urandom_range(0, 29) == 0);
            redirect_pc_i = $urandom;
            tick();
        end
        check("random_progress", {31'd0, (pops > 50)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: owns the program counter, drives the word address of the synchronous-read instruction RAM (1-cycle read latency, no enable), and captures the returned words. Fetched {pc, instruction} pairs go to decode over a valid/ready handshake. A 2-entry buffer absorbs the in-flight read when decode stalls. Branch/jump redirects flush all fetched and in-flight work.

## Interface
- DATAWIDTH, 32, instruction width; must equal the IRAM data width
- ADDRWIDTH, 5, IRAM word-address width
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset; bits [1:0] must be 0
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- iram_addr_o  out  ADDRWIDTH  IRAM word address, equal to pc_q[ADDRWIDTH+1:2]
- iram_data_i  in  DATAWIDTH  IRAM read data for the address driven the previous cycle
- halt_i  in  1  suppress new fetches; in-flight read still completes
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  redirect target byte PC; bits [1:0] ignored, forced 0
- valid_o  out  1  buffer head holds a fetched instruction
- ready_i  in  1  decode accepts head this cycle
- instr_o  out  DATAWIDTH  instruction at buffer head
- pc_o  out  32  byte PC of instr_o

## Operation
- State: pc_q (32b), inflight_q + inflight_pc_q, 2-entry buffer (count 0..2, head ptr), FSM {RUN, HALT}.
- Issue: a cycle is an issue cycle when state==RUN, halt_i==0, redirect_i==0, and (count + inflight_q - pop) < 2, where pop = valid_o & ready_i.
  - On issue: pc_q += 4; inflight_q <= 1; inflight_pc_q <= pc_q.
  - No issue: pc_q holds, so iram_addr_o is stable; inflight_q <= 0.
- Capture: when inflight_q==1 and redirect_i==0, {inflight_pc_q, iram_data_i} is written to the buffer tail. The issue rule guarantees no overflow.
- Pop: on valid_o & ready_i, the head advances. Push and pop may occur in the same cycle.
- Redirect (redirect_i==1):
  - Buffer is emptied (count <= 0) and inflight_q <= 0; the data arriving that cycle is discarded.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - A simultaneous pop is still counted as accepted by decode.
- FSM:
  - RUN -> HALT when halt_i==1.
  - HALT -> RUN when halt_i==0.
  - In HALT no issue occurs, captures continue, and redirects still update pc_q and flush.
- Wrap: pc_q wraps modulo 2^32. iram_addr_o wraps modulo 2^ADDRWIDTH words; pc_o keeps the full 32-bit value.
- Priority: rst_i > redirect_i > halt_i > normal issue.

## Timing
- Reset (rst_i high at an edge):
  - pc_q <= RESET_PC, so iram_addr_o = RESET_PC[ADDRWIDTH+1:2].
  - count <= 0, inflight_q <= 0, state <= RUN.
  - valid_o = 0; instr_o = 0 and pc_o = 0 while empty after reset.
- Reset mid-operation discards all buffered and in-flight entries.
- First fetch: the first cycle with rst_i low is an issue cycle. Data is captured at the end of the next cycle, and valid_o=1 one cycle after that. Reset-release to first valid_o is 2 cycles.
- Redirect latency: redirect_i high in cycle t gives the target address in t+1, capture at end of t+2, and valid_o with pc_o = target in t+3.
- Throughput: with ready_i held high, one instruction per cycle with consecutive PCs.
- Stall: ready_i low while count==1 and inflight==1 gives count 2 next cycle; issuing stops until a pop.
- Outputs are registered from the buffer; there is no combinational path from iram_data_i or ready_i to valid_o/instr_o/pc_o.

## Structure
- Package fetch_pkg holds:
  - PC_WIDTH = 32
  - INSTR_BYTES = 4
  - fetch_state_t enum {RUN, HALT}
  - typedef fetch_entry_t {pc, instr}
- One sub-module: fetch_skid_buf, a 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and head outputs.
- instr_fetch holds the PC, issue logic, in-flight tracking and FSM.

## Test plan
- Reset release, RESET_PC=0, ready_i=1, IRAM word n = 0x1000_0000+n:
  - valid_o first high 2 cycles after release.
  - pc_o sequence 0,4,8,... with instr_o 0x1000_0000, 0x1000_0001, ... and no bubbles.
- ready_i low for 5 cycles mid-stream:
  - count saturates at 2 and iram_addr_o freezes.
  - On release, PCs resume in order with no loss or duplicate.
- redirect_i with target 0x40 while count=2 and a read is in flight:
  - Next valid_o occurs exactly 3 cycles later with pc_o=0x40.
  - No stale PC appears.
- Redirect target 0x43 -> pc_o=0x40. Redirect asserted together with a pop -> the popped entry is counted once and the buffer is empty.
- ADDRWIDTH=5, fetch past pc 0x7C:
  - pc_o=0x80 carries word 0 data.
  - iram_addr_o wraps to 0.
- halt_i high for 4 cycles:
  - The in-flight word is still delivered and no new addresses issue.
  - rst_i asserted during halt -> valid_o=0 and iram_addr_o=RESET_PC word on the next cycle.
